// File: rtl/mem_access_unit.sv
// Load/store initiator for the memory controller data port: aligns accesses, extracts and extends load data.
// Define MEM_ACCESS_SPLIT_EN to split unaligned stores into bytes and crossing loads into two word reads.
//
// state   | meaning
// IDLE    | waiting for a request
// RD_A    | first (or only) word read address on the bus
// RD_B    | second word read address on the bus (split builds only)
// RD_WAIT | last read data returning; also the decode slot for refused accesses
// WR      | store beat(s) on the bus
// RESP    | response strobe
module mem_access_unit
`ifdef MEM_ACCESS_SPLIT_EN
#(
  parameter logic [3:0] PERI_BASE = 4'h8
)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_we,
  input  logic        i_req_unsigned,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_width,
  output logic        o_mem_we,
  output logic        o_mem_zeroextend,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
`ifdef MEM_ACCESS_SPLIT_EN
    RD_B    = 3'd2,
`endif
    RD_WAIT = 3'd3,
    WR      = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_width_q, mem_width_d;
  logic        mem_we_q, mem_we_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        req_unaligned;
  logic        req_fault;
  logic [1:0]  q_off;
  logic [1:0]  q_size;
  logic        q_uns;
  logic        q_fault;
  logic [31:0] ld_word;
  logic [31:0] ld_result;

`ifdef MEM_ACCESS_SPLIT_EN
  logic [2:0]  req_nbytes;
  logic        req_cross;
  logic        req_split;
  logic [3:0]  req_end_nib;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;
  logic        q_cross;
  logic        q_bytewise;
  logic [1:0]  q_last;
  logic [1:0]  byte_cnt;
  logic [1:0]  cnt_nxt;
  logic [31:0] w0_q;
  logic [63:0] ld_pair;
`endif

  assign accept = i_req_valid && (state_q == IDLE);

  always_comb begin
    case (i_req_size)
      2'd1:    req_unaligned = 1'b0;
      2'd2:    req_unaligned = i_req_addr[0];
      default: req_unaligned = |i_req_addr[1:0];
    endcase
  end

`ifdef MEM_ACCESS_SPLIT_EN
  always_comb begin
    case (i_req_size)
      2'd1:    req_nbytes = 3'd1;
      2'd2:    req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  assign req_cross   = ({1'b0, i_req_addr[1:0]} + req_nbytes) > 3'd4;
  assign req_split   = i_req_we ? req_unaligned : req_cross;
  assign req_end_nib = 4'((i_req_addr + {29'd0, req_nbytes} - 32'd1) >> 28);
  // Only accesses that actually get split are checked against the peripheral window.
  assign req_fault   = req_split &&
                       ((i_req_addr[31:28] == PERI_BASE) || (req_end_nib == PERI_BASE));
  assign cnt_nxt     = byte_cnt + 2'd1;
  assign ld_pair     = q_cross ? {i_mem_rdata, w0_q} : {32'd0, i_mem_rdata};
  assign ld_word     = 32'(ld_pair >> {q_off, 3'b000});
`else
  assign req_fault   = req_unaligned;
  assign ld_word     = i_mem_rdata >> {q_off, 3'b000};
`endif

  always_comb begin
    case (q_size)
      2'd1:    ld_result = q_uns ? {24'd0, ld_word[7:0]}  : {{24{ld_word[7]}}, ld_word[7:0]};
      2'd2:    ld_result = q_uns ? {16'd0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  // Request capture and split-access bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_off   <= 2'd0;
      q_size  <= 2'd0;
      q_uns   <= 1'b0;
      q_fault <= 1'b0;
`ifdef MEM_ACCESS_SPLIT_EN
      q_addr     <= 32'd0;
      q_wdata    <= 32'd0;
      q_cross    <= 1'b0;
      q_bytewise <= 1'b0;
      q_last     <= 2'd0;
      byte_cnt   <= 2'd0;
      w0_q       <= 32'd0;
`endif
    end else begin
      if (accept) begin
        q_off   <= i_req_addr[1:0];
        q_size  <= i_req_size;
        q_uns   <= i_req_unsigned;
        q_fault <= req_fault;
`ifdef MEM_ACCESS_SPLIT_EN
        q_addr     <= i_req_addr;
        q_wdata    <= i_req_wdata;
        q_cross    <= req_cross;
        q_bytewise <= i_req_we && req_unaligned;
        q_last     <= 2'(req_nbytes - 3'd1);
        byte_cnt   <= 2'd0;
`endif
      end
`ifdef MEM_ACCESS_SPLIT_EN
      if (state_q == WR && q_bytewise && byte_cnt != q_last) byte_cnt <= cnt_nxt;
      if (state_q == RD_B) w0_q <= i_mem_rdata;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_width_q  <= 2'd0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_width_q  <= mem_width_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_width_d  = mem_width_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = 32'd0;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          // Refused accesses take one slot in RD_WAIT so they never touch the bus.
          if (req_fault) begin
            state_d = RD_WAIT;
          end else if (i_req_we) begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = i_req_addr;
            mem_width_d = i_req_size;
            mem_wdata_d = i_req_wdata;
`ifdef MEM_ACCESS_SPLIT_EN
            if (req_unaligned) begin
              mem_width_d = 2'd1;
              mem_wdata_d = {24'd0, i_req_wdata[7:0]};
            end
`endif
          end else begin
            state_d     = RD_A;
            mem_addr_d  = {i_req_addr[31:2], 2'b00};
            mem_width_d = 2'd0;
          end
        end
      end
      RD_A: begin
`ifdef MEM_ACCESS_SPLIT_EN
        if (q_cross) begin
          state_d    = RD_B;
          mem_addr_d = mem_addr_q + 32'd4;
        end else begin
          state_d = RD_WAIT;
        end
`else
        state_d = RD_WAIT;
`endif
      end
`ifdef MEM_ACCESS_SPLIT_EN
      RD_B: state_d = RD_WAIT;
`endif
      RD_WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = q_fault;
        resp_rdata_d = q_fault ? 32'd0 : ld_result;
      end
      WR: begin
`ifdef MEM_ACCESS_SPLIT_EN
        if (q_bytewise && byte_cnt != q_last) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = q_addr + {30'd0, cnt_nxt};
          mem_wdata_d = {24'd0, 8'(q_wdata >> {cnt_nxt, 3'b000})};
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end
`else
        state_d      = RESP;
        resp_valid_d = 1'b1;
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_req_ready      = i_rst_n && (state_q == IDLE);
  assign o_resp_valid     = resp_valid_q;
  assign o_resp_fault     = resp_fault_q;
  assign o_resp_rdata     = resp_rdata_q;
  assign o_mem_addr       = mem_addr_q;
  assign o_mem_wdata      = mem_wdata_q;
  assign o_mem_width      = mem_width_q;
  assign o_mem_we         = mem_we_q;
  assign o_mem_zeroextend = 1'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit; expectations follow MEM_ACCESS_SPLIT_EN.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_we = 1'b0;
  logic        i_req_unsigned = 1'b0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_fault;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_width;
  logic        o_mem_we;
  logic        o_mem_zeroextend;
  logic [31:0] i_mem_rdata;

  mem_access_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
    .i_req_we(i_req_we), .i_req_unsigned(i_req_unsigned),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_fault(o_resp_fault),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_width(o_mem_width),
    .o_mem_we(o_mem_we), .o_mem_zeroextend(o_mem_zeroextend), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: data for the address presented last cycle; two words per vector.
  logic [31:0] cur_a = 32'd0, cur_lo = 32'd0, cur_hi = 32'd0, mem_addr_d = 32'd0;
  logic [31:0] cur_b;
  assign cur_b = cur_a + 32'd4;
  always @(posedge i_clk) mem_addr_d <= o_mem_addr;
  assign i_mem_rdata = (mem_addr_d == cur_a) ? cur_lo :
                       (mem_addr_d == cur_b) ? cur_hi : 32'hBAD0_BAD0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [1:0]  wr_width_q[$];
  always @(negedge i_clk) begin
    if (i_rst_n && o_mem_we) begin
      wr_addr_q.push_back(o_mem_addr);
      wr_data_q.push_back(o_mem_wdata);
      wr_width_q.push_back(o_mem_width);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        we;
    logic        uns;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic we, input logic uns,
                              input logic [31:0] lo, input logic [31:0] hi,
                              input logic [31:0] exp_rdata, input logic exp_fault,
                              input int exp_lat, input int exp_wr);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.size = size; v.we = we; v.uns = uns;
    v.lo = lo; v.hi = hi; v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
    v.exp_lat = exp_lat; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic start_req(input vec_t v, output bit ok);
    cur_a = {v.addr[31:2], 2'b00};
    cur_lo = v.lo;
    cur_hi = v.hi;
    wr_addr_q.delete(); wr_data_q.delete(); wr_width_q.delete();
    @(negedge i_clk);
    i_req_addr = v.addr; i_req_wdata = v.wdata; i_req_size = v.size;
    i_req_we = v.we; i_req_unsigned = v.uns; i_req_valid = 1'b1;
    ok = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (o_req_ready) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
  endtask

  // lat = number of clock edges after the accept edge before the response cycle.
  task automatic run_req(input vec_t v, output int lat, output logic [31:0] rd, output logic flt,
                         output logic [31:0] a1, output logic [1:0] w1, output logic [31:0] a2);
    bit ok;
    lat = -1; rd = 32'd0; flt = 1'b0; a1 = 32'd0; w1 = 2'd0; a2 = 32'd0;
    start_req(v, ok);
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (c == 0) begin a1 = o_mem_addr; w1 = o_mem_width; end
      if (c == 1) a2 = o_mem_addr;
      if (o_resp_valid) begin lat = c; rd = o_resp_rdata; flt = o_resp_fault; break; end
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd, a1, a2, tmp;
    logic [1:0] w1;
    logic flt;
    bit ok;
    vec_t rv;

    vecs.push_back(mk(32'h4000_0010, 32'h0, 2'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0));
    vecs.push_back(mk(32'h4000_0013, 32'h0, 2'd1, 1'b0, 1'b0, 32'h80FF_0000, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0));
    vecs.push_back(mk(32'h4000_0013, 32'h0, 2'd1, 1'b0, 1'b1, 32'h80FF_0000, 32'h0, 32'h0000_0080, 1'b0, 2, 0));
    vecs.push_back(mk(32'h4000_0012, 32'h0, 2'd2, 1'b0, 1'b0, 32'h80FF_0000, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 0));
    vecs.push_back(mk(32'h4000_0010, 32'h0, 2'd2, 1'b0, 1'b1, 32'h1234_8765, 32'h0, 32'h0000_8765, 1'b0, 2, 0));
    vecs.push_back(mk(32'h4000_0011, 32'h0, 2'd1, 1'b0, 1'b0, 32'h1234_8765, 32'h0, 32'hFFFF_FF87, 1'b0, 2, 0));
    vecs.push_back(mk(32'h4000_0020, 32'hCAFE_F00D, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
    vecs.push_back(mk(32'h4000_0021, 32'h0000_00A5, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
    vecs.push_back(mk(32'h4000_0022, 32'h0000_BEEF, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
    vecs.push_back(SPLIT ? mk(32'h4000_0003, 32'h0, 2'd2, 1'b0, 1'b1, 32'h1122_3344, 32'h5566_7788, 32'h0000_8811, 1'b0, 3, 0)
                         : mk(32'h4000_0003, 32'h0, 2'd2, 1'b0, 1'b1, 32'h1122_3344, 32'h5566_7788, 32'h0, 1'b1, 1, 0));
    vecs.push_back(SPLIT ? mk(32'h4000_0003, 32'h0, 2'd2, 1'b0, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'hFFFF_8811, 1'b0, 3, 0)
                         : mk(32'h4000_0003, 32'h0, 2'd2, 1'b0, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'h0, 1'b1, 1, 0));
    vecs.push_back(SPLIT ? mk(32'h4000_0001, 32'h0, 2'd2, 1'b0, 1'b0, 32'h1122_3344, 32'h0, 32'h0000_2233, 1'b0, 2, 0)
                         : mk(32'h4000_0001, 32'h0, 2'd2, 1'b0, 1'b0, 32'h1122_3344, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(SPLIT ? mk(32'h4000_0002, 32'h0, 2'd0, 1'b0, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'h7788_1122, 1'b0, 3, 0)
                         : mk(32'h4000_0002, 32'h0, 2'd0, 1'b0, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(32'h8000_0002, 32'hA1B2_C3D4, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(SPLIT ? mk(32'h4000_0001, 32'hA1B2_C3D4, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4, 4)
                         : mk(32'h4000_0001, 32'hA1B2_C3D4, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(SPLIT ? mk(32'h4000_0005, 32'h0000_BEEF, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2, 2)
                         : mk(32'h4000_0005, 32'h0000_BEEF, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(32'h7FFF_FFFE, 32'h0, 2'd0, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(32'h8000_0000, 32'h1234_5678, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
    vecs.push_back(SPLIT ? mk(32'hFFFF_FFFF, 32'h0, 2'd2, 1'b0, 1'b0, 32'hAA00_0000, 32'h0000_00BB, 32'hFFFF_BBAA, 1'b0, 3, 0)
                         : mk(32'hFFFF_FFFF, 32'h0, 2'd2, 1'b0, 1'b0, 32'hAA00_0000, 32'h0000_00BB, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(32'h8000_0003, 32'h0, 2'd1, 1'b0, 1'b0, 32'h7F00_0000, 32'h0, 32'h0000_007F, 1'b0, 2, 0));

    #12;
    check("reset ready", 32'(o_req_ready), 32'd0);
    check("reset resp_valid", 32'(o_resp_valid), 32'd0);
    check("reset resp_fault", 32'(o_resp_fault), 32'd0);
    check("reset resp_rdata", o_resp_rdata, 32'd0);
    check("reset mem_we", 32'(o_mem_we), 32'd0);
    check("reset mem_addr", o_mem_addr, 32'd0);
    check("reset mem_wdata", o_mem_wdata, 32'd0);
    check("reset mem_width", 32'(o_mem_width), 32'd0);
    check("reset zeroextend", 32'(o_mem_zeroextend), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      run_req(v, lat, rd, flt, a1, w1, a2);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d rdata", i), rd, v.exp_rdata);
      check($sformatf("v%0d fault", i), 32'(flt), 32'(v.exp_fault));
      check($sformatf("v%0d write count", i), 32'(wr_addr_q.size()), 32'(v.exp_wr));
      for (int k = 0; k < wr_addr_q.size() && k < v.exp_wr; k++) begin
        if (v.exp_wr == 1) begin
          check($sformatf("v%0d wr addr", i), wr_addr_q[k], v.addr);
          check($sformatf("v%0d wr width", i), 32'(wr_width_q[k]), 32'(v.size));
          check($sformatf("v%0d wr data", i), wr_data_q[k], v.wdata);
        end else begin
          tmp = v.wdata >> (8 * k);
          check($sformatf("v%0d byte%0d addr", i, k), wr_addr_q[k], v.addr + 32'(k));
          check($sformatf("v%0d byte%0d width", i, k), 32'(wr_width_q[k]), 32'd1);
          check($sformatf("v%0d byte%0d data", i, k), 32'(wr_data_q[k][7:0]), 32'(tmp[7:0]));
        end
      end
      if (!v.we && !v.exp_fault) begin
        check($sformatf("v%0d rd addr A", i), a1, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d rd width", i), 32'(w1), 32'd0);
        if (v.exp_lat == 3) check($sformatf("v%0d rd addr B", i), a2, {v.addr[31:2], 2'b00} + 32'd4);
      end
      @(negedge i_clk);
      check($sformatf("v%0d resp one cycle", i), 32'(o_resp_valid), 32'd0);
      check($sformatf("v%0d ready after resp", i), 32'(o_req_ready), 32'd1);
    end

    // Reset while a store is on the bus (second byte beat when splitting).
    rv = SPLIT ? mk(32'h4000_0001, 32'hA1B2_C3D4, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4, 4)
               : mk(32'h4000_0020, 32'h5A5A_5A5A, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1);
    start_req(rv, ok);
    check("rst test accept", 32'(ok), 32'd1);
    @(negedge i_clk);
    if (SPLIT) @(negedge i_clk);
    check("rst test we before", 32'(o_mem_we), 32'd1);
    check("rst test addr before", o_mem_addr, SPLIT ? 32'h4000_0002 : 32'h4000_0020);
    #1 i_rst_n = 1'b0;
    #1;
    check("rst test we", 32'(o_mem_we), 32'd0);
    check("rst test resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst test ready", 32'(o_req_ready), 32'd0);
    check("rst test addr", o_mem_addr, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst test ready after", 32'(o_req_ready), 32'd1);
    run_req(vecs[0], lat, rd, flt, a1, w1, a2);
    check("post-reset load latency", 32'(lat), 32'd2);
    check("post-reset load rdata", rd, 32'hDEAD_BEEF);
    check("post-reset load fault", 32'(flt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
